stream_demux: RTL and testbench

Parametrised 1-to-N stream demultiplexer with valid/ready handshaking and a one-entry registered output slot per channel. Each accepted input beat is routed by its `in_sel` tag to one output channel and presented there one cycle later, with backpressure tracked independently per channel. It generalises the team's single-bit 1:2 combinational demux to wide data, N channels, flow control and out-of-range-select handling. It sits between a single producer and N independent consumers in the datapath.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_if.sv | 30 +++
 rtl/demux_slot.sv | 46 ++++
 rtl/stream_demux.sv | 86 ++++++++
 tb/tb_stream_demux.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int                    DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer/consumer bus of the stream demux: one input stream, N output streams.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4
);
    localparam int SEL_W = $clog2(N_OUT);

    logic [WIDTH-1:0]            in_data;
    logic [SEL_W-1:0]            in_sel;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_OUT-1:0][WIDTH-1:0] out_data;
    logic [N_OUT-1:0]            out_valid;
    logic [N_OUT-1:0]            out_ready;
    logic [DROP_CNT_W-1:0]       drop_cnt;

    // Demux side
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );

    // Producer/consumer side
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry output register with valid/ready; a load may coincide with a drain.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,        // input transfer targeting this slot
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             slot_ready   // slot can take a beat this cycle
);
    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // State and payload registers; reset empties the slot immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: load wins (fill or reload), otherwise a drain empties the slot
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (state_q == SLOT_FULL && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = data_q;
    assign slot_ready = (state_q == SLOT_EMPTY) || out_ready;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N stream demux: routes each accepted beat to a per-channel registered slot.
// Out-of-range selects are accepted, discarded and counted.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4
) (
    input logic           clk,
    input logic           rst,
    stream_demux_if.slave bus
);
    localparam int SEL_W = $clog2(N_OUT);

    logic [SEL_W-1:0]            sel;
    logic                        in_range;
    logic [N_OUT-1:0]            sel_hit;
    logic [N_OUT-1:0]            slot_rdy;
    logic [N_OUT-1:0]            load;
    logic [N_OUT-1:0]            out_valid_w;
    logic [N_OUT-1:0][WIDTH-1:0] out_data_w;
    logic                        in_ready_c;
    logic                        xfer;
    logic                        drop;
    logic [DROP_CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

    assign sel = bus.in_sel;

    // With a power-of-two channel count every select value is a real channel
    if ((1 << SEL_W) == N_OUT) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (32'(sel) < N_OUT);
    end

    // One-hot decode of the select tag
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (32'(sel) == k);
        end
    end

    // Ready looks only at the addressed slot; drops are always accepted
    always_comb begin
        in_ready_c = 1'b0;
        if (!rst) begin
            in_ready_c = in_range ? |(sel_hit & slot_rdy) : 1'b1;
        end
    end

    assign xfer = bus.in_valid && in_ready_c;
    assign load = {N_OUT{xfer}} & sel_hit;
    assign drop = xfer && !in_range;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[k]),
            .load_data  (bus.in_data),
            .out_ready  (bus.out_ready[k]),
            .out_valid  (out_valid_w[k]),
            .out_data   (out_data_w[k]),
            .slot_ready (slot_rdy[k])
        );
    end

    // Drop counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    // Count discarded beats, holding at the maximum
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance and a 3-channel
// instance (the latter exercises the out-of-range drop path).
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    stream_demux_if #(.WIDTH(8), .N_OUT(4)) bus4 ();
    stream_demux_if #(.WIDTH(8), .N_OUT(3)) bus3 ();

    stream_demux #(.WIDTH(8), .N_OUT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    stream_demux #(.WIDTH(8), .N_OUT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rdy_bad;
        int vld_bad;

        bus4.in_valid  = 1'b1;
        bus4.in_sel    = 2'd2;
        bus4.in_data   = 8'hA5;
        bus4.out_ready = 4'hF;
        bus3.in_valid  = 1'b0;
        bus3.in_sel    = 2'd0;
        bus3.in_data   = 8'h00;
        bus3.out_ready = 3'h7;

        // Reset held for 3 cycles with a beat offered
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus4.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        check("rst_out_data",  64'(bus4.out_data),  64'd0);
        check("rst_drop_cnt",  64'(bus4.drop_cnt),  64'd0);

        // First beat after release: 0xA5 to channel 2
        rst = 1'b0;
        #1;
        check("first_in_ready", 64'(bus4.in_ready), 64'd1);
        step();
        bus4.in_valid = 1'b0;
        check("first_valid", 64'(bus4.out_valid),   64'b0100);
        check("first_data",  64'(bus4.out_data[2]), 64'hA5);
        step();
        check("first_drained", 64'(bus4.out_valid), 64'd0);

        // Sweep all channels back to back with consumers always ready
        for (int k = 0; k < 4; k++) begin
            bus4.in_valid = 1'b1;
            bus4.in_sel   = 2'(k);
            bus4.in_data  = 8'(8'h10 + k);
            step();
            check($sformatf("sweep_valid_%0d", k), 64'(bus4.out_valid),   64'(1 << k));
            check($sformatf("sweep_data_%0d",  k), 64'(bus4.out_data[k]), 64'(8'h10 + k));
        end
        bus4.in_valid = 1'b0;
        step();
        check("sweep_idle", 64'(bus4.out_valid), 64'd0);

        // Backpressure on channel 1 must not stall channel 3
        bus4.out_ready = 4'b1101;
        bus4.in_valid  = 1'b1;
        bus4.in_sel    = 2'd1;
        bus4.in_data   = 8'h11;
        step();
        check("bp_fill_valid", 64'(bus4.out_valid),   64'b0010);
        check("bp_fill_data",  64'(bus4.out_data[1]), 64'h11);
        bus4.in_data = 8'h99;
        #1;
        check("bp_stall_ready", 64'(bus4.in_ready), 64'd0);
        step();
        check("bp_stall_data",  64'(bus4.out_data[1]), 64'h11);
        check("bp_stall_valid", 64'(bus4.out_valid),   64'b0010);
        for (int i = 0; i < 3; i++) begin
            bus4.in_sel  = 2'd3;
            bus4.in_data = 8'(8'h30 + i);
            #1;
            check($sformatf("bp_ch3_ready_%0d", i), 64'(bus4.in_ready), 64'd1);
            step();
            check($sformatf("bp_ch3_valid_%0d", i), 64'(bus4.out_valid), 64'b1010);
            check($sformatf("bp_ch3_data_%0d",  i), 64'(bus4.out_data[3]), 64'(8'h30 + i));
            check($sformatf("bp_ch1_hold_%0d",  i), 64'(bus4.out_data[1]), 64'h11);
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 4'hF;
        step();
        check("bp_release", 64'(bus4.out_valid), 64'd0);

        // Reload: drain and refill channel 0 in one cycle
        bus4.out_ready = 4'b1110;
        bus4.in_valid  = 1'b1;
        bus4.in_sel    = 2'd0;
        bus4.in_data   = 8'h01;
        step();
        check("reload_first", 64'(bus4.out_data[0]), 64'h01);
        bus4.out_ready = 4'hF;
        bus4.in_data   = 8'h02;
        #1;
        check("reload_ready", 64'(bus4.in_ready), 64'd1);
        step();
        bus4.in_valid = 1'b0;
        check("reload_valid", 64'(bus4.out_valid),   64'b0001);
        check("reload_data",  64'(bus4.out_data[0]), 64'h02);
        step();
        check("reload_drained", 64'(bus4.out_valid), 64'd0);

        // Drop path on the 3-channel instance: select 3 is out of range
        rdy_bad = 0;
        vld_bad = 0;
        bus3.in_valid = 1'b1;
        bus3.in_sel   = 2'd3;
        bus3.in_data  = 8'h77;
        for (int i = 0; i < 260; i++) begin
            #1;
            if (bus3.in_ready !== 1'b1) rdy_bad++;
            step();
            if (bus3.out_valid !== 3'b000) vld_bad++;
            if (i == 99) check("drop_cnt_100", 64'(bus3.drop_cnt), 64'd100);
        end
        bus3.in_valid = 1'b0;
        check("drop_ready_bad", 64'(rdy_bad), 64'd0);
        check("drop_valid_bad", 64'(vld_bad), 64'd0);
        check("drop_cnt_sat",   64'(bus3.drop_cnt), 64'd255);
        check("drop_cnt_other", 64'(bus4.drop_cnt), 64'd0);

        // Asynchronous reset with two full slots
        bus4.out_ready = 4'b0000;
        bus4.in_valid  = 1'b1;
        bus4.in_sel    = 2'd0;
        bus4.in_data   = 8'h41;
        step();
        bus4.in_sel  = 2'd2;
        bus4.in_data = 8'h42;
        step();
        bus4.in_valid = 1'b0;
        check("mid_full", 64'(bus4.out_valid), 64'b0101);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus4.out_valid), 64'd0);
        check("mid_rst_data",  64'(bus4.out_data),  64'd0);
        check("mid_rst_drop3", 64'(bus3.drop_cnt),  64'd0);
        step();
        rst = 1'b0;
        bus4.out_ready = 4'hF;
        bus4.in_valid  = 1'b1;
        bus4.in_sel    = 2'd1;
        bus4.in_data   = 8'h5A;
        #1;
        check("post_rst_ready", 64'(bus4.in_ready), 64'd1);
        step();
        bus4.in_valid = 1'b0;
        check("post_rst_valid", 64'(bus4.out_valid),   64'b0010);
        check("post_rst_data",  64'(bus4.out_data[1]), 64'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
